atconv_mem_host: RTL and testbench

- Host-side responder for the atrous-conv accelerator's memory interface: owns the 64x64 image memory, the layer-0 memory (4096 words) and the layer-1 memory (1024 words).
- Loads the image from an upstream stream, raises `ready`, and serves accelerator reads (`iaddr`/`idata`, `crd`/`caddr_rd`/`cdata_rd`).
- Captures accelerator writes (`cwr`/`csel`/`caddr_wr`/`cdata_wr`).
- After `busy` falls, streams the layer-1 result out downstream.

---
 rtl/atconv_mem_host.sv | 111 +++++++++++
 tb/tb_atconv_mem_host.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/atconv_mem_host.sv
// atconv_mem_host: host-side memory responder for the atrous-conv accelerator
//   clk, reset (async, active-low)
//   load_valid/load_data/load_ready : upstream image stream, raster order
//   ready/busy                      : start handshake with the accelerator
//   iaddr/idata                     : combinational image read port
//   cwr/csel/caddr_wr/cdata_wr      : layer-0/layer-1 write port (RUN only)
//   crd/caddr_rd/cdata_rd           : combinational layer read port
//   out_valid/out_data/out_last/out_ready/done : layer-1 result stream
module atconv_mem_host #(
  parameter int DW        = 13,
  parameter int IMG_DEPTH = 4096,
  parameter int L1_DEPTH  = 1024,
  parameter int AW        = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic          csel,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          done
);
  localparam int L1W = $clog2(L1_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP, S_FIN} state_t;
  state_t        r_state, w_next;
  logic [AW:0]   r_load_cnt;
  logic [10:0]   r_out_cnt;
  logic [DW-1:0] r_out_data;
  logic [DW-1:0] r_img [IMG_DEPTH];
  logic [DW-1:0] r_l0  [IMG_DEPTH];
  logic [DW-1:0] r_l1  [L1_DEPTH];
  logic          w_load_fire, w_load_end, w_out_last, w_out_fire, w_run_wr;
  assign w_load_fire = load_valid && r_state == S_LOAD;
  assign w_load_end  = w_load_fire && r_load_cnt == (AW+1)'(IMG_DEPTH-1);
  assign w_out_last  = r_out_cnt == 11'(L1_DEPTH-1);
  assign w_out_fire  = r_state == S_DUMP && out_ready;
  assign w_run_wr    = r_state == S_RUN && cwr;
  assign idata       = r_img[iaddr];
  assign cdata_rd    = !crd ? '0 : csel ? r_l1[caddr_rd[L1W-1:0]] : r_l0[caddr_rd];
  assign out_data    = r_out_data;
  always_comb begin
    w_next     = r_state;
    load_ready = 1'b0;
    ready      = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_IDLE:  w_next = S_LOAD;
      S_LOAD:  begin
        load_ready = 1'b1;
        if (w_load_end) w_next = S_START;
      end
      S_START: begin
        ready = 1'b1;
        if (busy) w_next = S_RUN;
      end
      S_RUN:   if (!busy) w_next = S_DUMP;
      S_DUMP:  begin
        out_valid = 1'b1;
        out_last  = w_out_last;
        if (out_ready && w_out_last) w_next = S_FIN;
      end
      S_FIN:   begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  // out_data is prefetched: word 0 on the RUN->DUMP edge, word n+1 on the transfer of word n
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_load_cnt <= '0;
      r_out_cnt  <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) r_load_cnt <= '0;
      else if (w_load_fire) r_load_cnt <= r_load_cnt + 1'b1;
      if (r_state == S_RUN && !busy) begin
        r_out_cnt  <= '0;
        r_out_data <= r_l1[0];
      end else if (w_out_fire && !w_out_last) begin
        r_out_cnt  <= r_out_cnt + 11'd1;
        r_out_data <= r_l1[L1W'(r_out_cnt + 11'd1)];
      end
    end
  end
  // memories are never cleared; out-of-range layer-1 writes are dropped, not aliased
  always_ff @(posedge clk) begin
    if (w_load_fire) r_img[r_load_cnt[AW-1:0]] <= load_data;
    if (w_run_wr && !csel) r_l0[caddr_wr] <= cdata_wr;
    if (w_run_wr && csel && caddr_wr < AW'(L1_DEPTH)) r_l1[caddr_wr[L1W-1:0]] <= cdata_wr;
  end
endmodule

// File: tb/tb_atconv_mem_host.sv
// tb_atconv_mem_host: randomized self-checking bench against an array-based memory model
module tb_atconv_mem_host;
  localparam int DW  = 13;
  localparam int AW  = 12;
  localparam int IMG = 4096;
  localparam int L1  = 1024;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready, ready, out_valid, out_last, done;
  logic          busy = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic [DW-1:0] idata, cdata_rd, out_data;
  logic          cwr = 1'b0, csel = 1'b0, crd = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] caddr_wr = '0, caddr_rd = '0;
  logic [DW-1:0] cdata_wr = '0;
  int total = 0;
  int bad = 0;
  int load_ptr = 0;
  logic [DW-1:0] img_m [IMG];
  logic [DW-1:0] l0_m  [IMG];
  logic [DW-1:0] l1_m  [L1];
  bit            l0_v  [IMG];
  bit            l1_v  [L1];

  atconv_mem_host dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .csel(csel), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int n, input bit ramp, input bit gaps);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 20000) begin
      load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      load_data  = ramp ? DW'(load_ptr) : DW'($urandom);
      @(negedge clk);
      if (load_valid && load_ready) begin
        img_m[load_ptr] = load_data;
        load_ptr++;
        got++;
      end
      step;
      cyc++;
    end
    load_valid = 1'b0;
    chk("load_count", got, n);
  endtask

  task automatic acc_cycle(input bit w, input bit s, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input bit r, input logic [AW-1:0] ra);
    logic [DW-1:0] e;
    bit known;
    cwr = w; csel = s; caddr_wr = wa; cdata_wr = wd; crd = r; caddr_rd = ra;
    iaddr = AW'($urandom);
    @(negedge clk);
    chk("idata", idata, img_m[iaddr]);
    known = !r || (s ? l1_v[ra[9:0]] : l0_v[ra]);
    e = !r ? '0 : s ? l1_m[ra[9:0]] : l0_m[ra];
    if (known) chk("cdata_rd", cdata_rd, e);
    @(posedge clk);
    if (w && !s) begin
      l0_m[wa] = wd;
      l0_v[wa] = 1'b1;
    end else if (w && wa < 12'(L1)) begin
      l1_m[wa[9:0]] = wd;
      l1_v[wa[9:0]] = 1'b1;
    end
    #1;
    cwr = 1'b0;
    crd = 1'b0;
  endtask

  task automatic traffic(input int n);
    bit s;
    logic [AW-1:0] wa, ra;
    for (int i = 0; i < n; i++) begin
      s  = 1'($urandom);
      wa = (s && $urandom_range(0, 7) == 0) ? AW'($urandom_range(L1, IMG-1)) : AW'($urandom_range(0, 63));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 63));
      acc_cycle(1'($urandom), s, wa, DW'($urandom), 1'($urandom), ra);
    end
  endtask

  task automatic handshake;
    cwr = 1'b1; csel = 1'b0; caddr_wr = 12'hfff; cdata_wr = 13'h1abc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ready_hold", ready, 1);
      step;
    end
    cwr = 1'b0;
    busy = 1'b1;
    @(negedge clk);
    chk("ready_before_busy", ready, 1);
    step;
    chk("ready_drop", ready, 0);
  endtask

  task automatic dump(input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit rdy = 1'b0;
    busy = 1'b0;
    step;
    while (idx < L1 && cyc < 6000) begin
      rdy = toggle ? ~rdy : 1'($urandom);
      out_ready = rdy;
      @(negedge clk);
      chk("done_early", done, 0);
      if (out_valid) begin
        chk("out_data", out_data, l1_m[idx]);
        chk("out_last", out_last, idx == L1-1);
        if (rdy) idx++;
      end
      step;
      cyc++;
    end
    out_ready = 1'b0;
    chk("dump_words", idx, L1);
    @(negedge clk);
    chk("valid_after_last", out_valid, 0);
    chk("done_pulse", done, 1);
    step;
    @(negedge clk);
    chk("done_once", done, 0);
    step;
  endtask

  initial begin
    #3;
    chk("rst_load_ready", load_ready, 0);
    chk("rst_ready", ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    step;
    reset = 1'b1;
    load_words(IMG, 1'b1, 1'b0);
    chk("load_ready_end", load_ready, 0);
    chk("ready_rise", ready, 1);
    iaddr = 12'd100;
    #1;
    chk("idata_100", idata, 100);
    for (int i = 0; i < 6; i++) begin
      iaddr = AW'($urandom);
      #1;
      chk("idata_start", idata, img_m[iaddr]);
    end
    handshake;
    acc_cycle(1'b1, 1'b0, 12'hfff, 13'h0123, 1'b0, '0);
    acc_cycle(1'b0, 1'b0, '0, '0, 1'b1, 12'hfff);
    traffic(300);
    for (int k = 0; k < L1; k++) acc_cycle(1'b1, 1'b1, AW'(k), DW'(k), 1'b0, '0);
    acc_cycle(1'b1, 1'b1, 12'd1500, 13'h1fff, 1'b1, 12'd476);
    acc_cycle(1'b1, 1'b1, 12'd1029, 13'h1fff, 1'b1, 12'd5);
    dump(1'b1);
    load_words(2000, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_load_ready", load_ready, 0);
    chk("mid_ready", ready, 0);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_last", out_last, 0);
    chk("mid_done", done, 0);
    chk("mid_out_data", out_data, 0);
    load_ptr = 0;
    repeat (3) step;
    reset = 1'b1;
    load_words(IMG, 1'b0, 1'b1);
    chk("ready_rise2", ready, 1);
    handshake;
    acc_cycle(1'b0, 1'b0, '0, '0, 1'b1, 12'hfff);
    traffic(400);
    dump(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
